// File: rtl/dft_tx_pkg.sv
// Shared definitions for the data-fresh transmitter: state encoding and default strobe timing.
package dft_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_HIGH  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam int DFT_HIGH_CYC_DEF = 4;
   localparam int DFT_LOW_CYC_DEF  = 2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SETUP = ST_SETUP,
      S_HIGH  = ST_HIGH,
      S_GAP   = ST_GAP
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/data_fresh_tx_buf.sv
// One-entry holding register with full flag; lets the next word wait while a strobe is in flight.
module data_fresh_tx_buf
   import dft_tx_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full
);

   always_ff @(posedge clk) begin
      if (!rstn)
         full <= 1'b0;
      else if (wr)
         full <= 1'b1;
      else if (pop)
         full <= 1'b0;
   end

   // NOTE: the storage register has no reset; it is only ever read while full is set.
   always_ff @(posedge clk) begin
      if (wr)
         rd_data <= wr_data;
   end

endmodule

// File: rtl/data_fresh_tx.sv
// Data-fresh strobe transmitter: holds a word on data_out, then pulses fresh once per word.
// Optional one-entry input buffer enabled by defining DATA_FRESH_TX_BUF_EN.
module data_fresh_tx
   import dft_tx_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int HIGH_CYC = DFT_HIGH_CYC_DEF,
   parameter int LOW_CYC  = DFT_LOW_CYC_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              fresh,
   output logic              busy
);

   localparam int CNT_W = $clog2(max2(HIGH_CYC, LOW_CYC) + 1);
   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYC - 1);

   generate
      if (HIGH_CYC < 1 || LOW_CYC < 1) begin : g_param_err
         $error("data_fresh_tx: HIGH_CYC and LOW_CYC must both be >= 1");
      end
   endgenerate

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              xfer;
   logic              gap_end;
   logic              load_new;
   logic              load_buf;
   logic              buf_full;
   logic [DATA_W-1:0] buf_data;

   assign xfer    = in_valid && in_ready;
   assign gap_end = (state == S_GAP) && (cnt == '0);

`ifdef DATA_FRESH_TX_BUF_EN
   logic buf_wr;
   logic buf_pop;

   assign in_ready = rstn && !buf_full;
   // A transfer on the GAP-end edge implies an empty buffer, so that word goes straight to data_out.
   assign buf_wr   = xfer && (state != S_IDLE) && !gap_end;
   assign buf_pop  = gap_end && buf_full;

   data_fresh_tx_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk     (clk),
      .rstn    (rstn),
      .wr      (buf_wr),
      .wr_data (in_data),
      .pop     (buf_pop),
      .rd_data (buf_data),
      .full    (buf_full)
   );
`else
   assign in_ready = rstn && (state == S_IDLE);
   assign buf_full = 1'b0;
   assign buf_data = '0;
`endif

   assign load_new = xfer && ((state == S_IDLE) || gap_end);
   assign load_buf = gap_end && buf_full;
   assign busy     = (state != S_IDLE) || buf_full;

   // NOTE: all state and registered outputs use non-blocking assignments so every
   // branch below reads the pre-edge values of state and cnt.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         fresh    <= 1'b0;
         data_out <= '0;
      end else begin
         if (load_new)
            data_out <= in_data;
         else if (load_buf)
            data_out <= buf_data;

         case (state)
            S_IDLE: begin
               if (load_new)
                  state <= S_SETUP;
            end
            S_SETUP: begin
               state <= S_HIGH;
               cnt   <= HIGH_LOAD;
               fresh <= 1'b1;
            end
            S_HIGH: begin
               if (cnt == '0) begin
                  state <= S_GAP;
                  cnt   <= LOW_LOAD;
                  fresh <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_GAP: begin
               if (cnt == '0)
                  state <= (load_new || load_buf) ? S_SETUP : S_IDLE;
               else
                  cnt <= cnt - CNT_W'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_fresh_tx.sv
// Directed bench for data_fresh_tx: default instance plus a HIGH_CYC=1/LOW_CYC=1 instance,
// scoreboard queues checked on every fresh rising edge.
module tb_data_fresh_tx;

`ifdef DATA_FRESH_TX_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif
   localparam int HIGH = 4;
   localparam int LOW  = 2;
   localparam int PER  = BUF ? 1 + HIGH + LOW : 2 + HIGH + LOW;
   localparam int PER1 = BUF ? 3 : 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] in_data, in_data1;
   logic       in_valid, in_valid1;
   logic       in_ready, in_ready1;
   logic [7:0] data_out, data_out1;
   logic       fresh, fresh1;
   logic       busy, busy1;

   data_fresh_tx dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .data_out (data_out),
      .fresh    (fresh),
      .busy     (busy)
   );

   data_fresh_tx #(
      .DATA_W   (8),
      .HIGH_CYC (1),
      .LOW_CYC  (1)
   ) dut1 (
      .clk      (clk),
      .rstn     (rstn),
      .in_data  (in_data1),
      .in_valid (in_valid1),
      .in_ready (in_ready1),
      .data_out (data_out1),
      .fresh    (fresh1),
      .busy     (busy1)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         last_xfer;
   bit         abort;
   logic [7:0] q[$];
   logic [7:0] q1[$];
   int         rise_t[$];
   int         low_q[$];
   int         rise1_t[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sel, input logic [7:0] w);
      bit done = 1'b0;
      if (sel) begin
         in_valid1 = 1'b1;
         in_data1  = w;
      end else begin
         in_valid = 1'b1;
         in_data  = w;
      end
      for (int i = 0; i < 60 && !done; i++) begin
         if ((sel ? in_ready1 : in_ready) === 1'b1) begin
            if (sel) q1.push_back(w);
            else     q.push_back(w);
            last_xfer = cyc;
            done      = 1'b1;
         end
         tick();
      end
      check("send_accept", done, 1);
   endtask

   task automatic wait_idle(input bit sel);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         ok = ((sel ? busy1 : busy) === 1'b0);
      end
      check("idle_timeout", ok, 1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Default-instance monitor: data on each rising edge, hold while high, high length, low run.
   initial begin
      logic       pf = 1'b0;
      logic [7:0] pd = '0;
      int         hl = 0;
      int         ll = 0;
      forever begin
         @(negedge clk);
         if (fresh === 1'b1 && pf !== 1'b1) begin
            check("edge_expected", q.size() != 0, 1);
            if (q.size() != 0) check("edge_data", data_out, q.pop_front());
            check("setup_stable", data_out, pd);
            rise_t.push_back(cyc);
            low_q.push_back(ll);
            hl = 1;
         end else if (fresh === 1'b1) begin
            check("hold_stable", data_out, pd);
            hl++;
         end else if (pf === 1'b1) begin
            if (!abort) check("high_len", hl, HIGH);
            ll = 1;
         end else begin
            ll++;
         end
         pf = fresh;
         pd = data_out;
      end
   end

   initial begin
      logic       pf = 1'b0;
      logic [7:0] pd = '0;
      int         hl = 0;
      forever begin
         @(negedge clk);
         if (fresh1 === 1'b1 && pf !== 1'b1) begin
            check("edge1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) check("edge1_data", data_out1, q1.pop_front());
            check("setup1_stable", data_out1, pd);
            rise1_t.push_back(cyc);
            hl = 1;
         end else if (fresh1 === 1'b1) begin
            check("hold1_stable", data_out1, pd);
            hl++;
         end else if (pf === 1'b1) begin
            if (!abort) check("high1_len", hl, 1);
         end
         pf = fresh1;
         pd = data_out1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  nr, nr1, ta, tb;
      bit  ok;

      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
      in_data   = '0;
      in_data1  = '0;
      abort     = 1'b1;
      repeat (3) tick();
      check("rst_fresh", fresh, 0);
      check("rst_data", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_ready1", in_ready1, 0);
      rstn  = 1'b1;
      abort = 1'b0;
      tick();
      check("ready_after_rst", in_ready, 1);

      // Single word: strobe high edges N+1..N+4, ready again after N+7.
      send(1'b0, 8'hA5);
      in_valid = 1'b0;
      check("t1_data", data_out, 8'hA5);
      check("t1_setup_low", fresh, 0);
      check("t1_busy", busy, 1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("t1_fresh", fresh, k <= HIGH);
         check("t1_ready", in_ready, BUF || k >= 7);
      end
      check("t1_idle", busy, 0);
      check("t1_hold", data_out, 8'hA5);

      // Back-to-back stream with in_valid held.
      nr = rise_t.size();
      send(1'b0, 8'h01);
      ta = last_xfer;
      send(1'b0, 8'h02);
      tb = last_xfer;
      send(1'b0, 8'h03);
      in_valid = 1'b0;
      wait_idle(1'b0);
      check("stream_rises", rise_t.size() - nr, 3);
      check("stream_per_a", rise_t[nr+1] - rise_t[nr], PER);
      check("stream_per_b", rise_t[nr+2] - rise_t[nr+1], PER);
      check("stream_gap_a", low_q[nr+1], PER - HIGH);
      check("stream_gap_b", low_q[nr+2], PER - HIGH);
`ifdef DATA_FRESH_TX_BUF_EN
      check("buf_early_accept", (tb - ta) <= HIGH, 1);
`else
      check("ready_period", tb - ta, PER);

      // in_valid while busy: ignored, data_out untouched.
      send(1'b0, 8'h77);
      in_data = 8'h88;
      for (int k = 0; k <= 6; k++) begin
         check("busy_ready", in_ready, 0);
         check("busy_hold", data_out, 8'h77);
         if (k == 6) in_valid = 1'b0;
         tick();
      end
      wait_idle(1'b0);
      check("no_capture", data_out, 8'h77);
`endif

      // Reset during HIGH drops the in-flight (and buffered) word.
      send(1'b0, 8'h5A);
`ifdef DATA_FRESH_TX_BUF_EN
      send(1'b0, 8'h3C);
`endif
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (fresh === 1'b1) ok = 1'b1;
         else tick();
      end
      check("fresh_timeout", ok, 1);
      tick();
      nr    = rise_t.size();
      abort = 1'b1;
      rstn  = 1'b0;
      #1;
      check("rst_mid_ready", in_ready, 0);
      tick();
      check("rst_mid_fresh", fresh, 0);
      check("rst_mid_data", data_out, 0);
      check("rst_mid_busy", busy, 0);
      rstn = 1'b1;
      q.delete();
      repeat (20) tick();
      check("rst_no_edge", rise_t.size(), nr);
      check("rst_after_data", data_out, 0);
      check("rst_after_busy", busy, 0);
      abort = 1'b0;

      // Minimum timing instance: 1-cycle pulses.
      nr1 = rise1_t.size();
      send(1'b1, 8'hFF);
      send(1'b1, 8'h00);
      in_valid1 = 1'b0;
      wait_idle(1'b1);
      check("min_rises", rise1_t.size() - nr1, 2);
      check("min_period", rise1_t[nr1+1] - rise1_t[nr1], PER1);

      check("sb_empty", q.size(), 0);
      check("sb1_empty", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
